// File: rtl/noc_config_pkg.sv
// Shared NoC definitions: head-flit layout, packet types and head packing.
// Used by the local-port packetizer and the matching receiver.
package noc_config_pkg;

  localparam int HF_DEST_X_LSB = 0;
  localparam int HF_DEST_Y_LSB = 4;
  localparam int HF_SRC_X_LSB  = 8;
  localparam int HF_SRC_Y_LSB  = 12;
  localparam int HF_TYPE_LSB   = 16;
  localparam int HF_TAG_LSB    = 18;
  localparam int HF_LEN_LSB    = 26;
  localparam int HF_COORD_W    = 4;
  localparam int HF_TYPE_W     = 2;
  localparam int HF_TAG_W      = 8;
  localparam int HF_LEN_W      = 6;
  localparam int HF_W          = 32;

  typedef enum logic [1:0] {
    PKT_READ,
    PKT_WRITE,
    PKT_RESP,
    PKT_MSG
  } pkt_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } pkt_state_e;

  // Field order mirrors the wire layout, MSB first.
  typedef struct packed {
    logic [HF_LEN_W-1:0]   len;
    logic [HF_TAG_W-1:0]   tag;
    logic [HF_TYPE_W-1:0]  ptype;
    logic [HF_COORD_W-1:0] src_y;
    logic [HF_COORD_W-1:0] src_x;
    logic [HF_COORD_W-1:0] dest_y;
    logic [HF_COORD_W-1:0] dest_x;
  } head_t;

  function automatic logic [HF_W-1:0] pack_head(
    input logic [3:0] dest_x,
    input logic [3:0] dest_y,
    input logic [3:0] src_x,
    input logic [3:0] src_y,
    input logic [1:0] ptype,
    input logic [7:0] tag,
    input logic [5:0] len
  );
    head_t h;
    h.dest_x = dest_x;
    h.dest_y = dest_y;
    h.src_x  = src_x;
    h.src_y  = src_y;
    h.ptype  = ptype;
    h.tag    = tag;
    h.len    = len;
    return h;
  endfunction

endpackage

// File: rtl/noc_flit_packetizer.sv
// Local-port NI transmitter: request + payload words -> head/body flits.
// Define NOC_FLIT_PACKETIZER_PARITY_EN to register even parity per flit.
module noc_flit_packetizer
  import noc_config_pkg::*;
#(
  parameter int X           = 0,
  parameter int Y           = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PAYLOAD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_dest_x,
  input  logic [3:0]            req_dest_y,
  input  logic [1:0]            req_type,
  input  logic [7:0]            req_tag,
  input  logic [5:0]            req_length,
  input  logic                  pay_valid,
  output logic                  pay_ready,
  input  logic [DATA_WIDTH-1:0] pay_data,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  flit_head,
  output logic                  flit_tail,
  output logic [DATA_WIDTH-1:0] flit_data,
  output logic                  flit_parity,
  output logic                  err_length
);

  localparam logic [5:0] MAX_LEN = 6'(MAX_PAYLOAD);
  localparam logic [3:0] SRC_X   = 4'(X);
  localparam logic [3:0] SRC_Y   = 4'(Y);

  pkt_state_e            state;
  pkt_state_e            state_nxt;
  logic [5:0]            remaining;
  logic [5:0]            rem_nxt;
  logic                  valid_nxt;
  logic                  head_nxt;
  logic                  tail_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  err_nxt;
  logic                  out_free;
  logic                  over;
  logic [5:0]            eff_len;
  logic                  req_fire;
  logic                  pay_fire;

  assign out_free  = !flit_valid || flit_ready;
  assign req_ready = !rst && (state == ST_IDLE) && out_free;
  assign pay_ready = !rst && (state == ST_BODY) && out_free;
  assign req_fire  = req_valid && req_ready;
  assign pay_fire  = pay_valid && pay_ready;
  assign over      = req_length > MAX_LEN;
  assign eff_len   = over ? MAX_LEN : req_length;

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    valid_nxt = flit_valid && !flit_ready;
    head_nxt  = flit_head;
    tail_nxt  = flit_tail;
    data_nxt  = flit_data;
    err_nxt   = 1'b0;
    unique case (1'b1)
      state == ST_IDLE: begin
        if (req_fire) begin
          valid_nxt = 1'b1;
          head_nxt  = 1'b1;
          err_nxt   = over;
          data_nxt  = DATA_WIDTH'(pack_head(req_dest_x, req_dest_y,
                        SRC_X, SRC_Y, req_type, req_tag, eff_len));
          if (eff_len == 6'd0) begin
            tail_nxt = 1'b1;
          end else begin
            tail_nxt  = 1'b0;
            rem_nxt   = eff_len;
            state_nxt = ST_BODY;
          end
        end
      end
      state == ST_BODY: begin
        if (pay_fire) begin
          valid_nxt = 1'b1;
          head_nxt  = 1'b0;
          data_nxt  = pay_data;
          rem_nxt   = remaining - 6'd1;
          tail_nxt  = (remaining == 6'd1);
          if (remaining == 6'd1) state_nxt = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      flit_valid <= 1'b0;
      flit_head  <= 1'b0;
      flit_tail  <= 1'b0;
      flit_data  <= '0;
      err_length <= 1'b0;
    end else begin
      state      <= state_nxt;
      remaining  <= rem_nxt;
      flit_valid <= valid_nxt;
      flit_head  <= head_nxt;
      flit_tail  <= tail_nxt;
      flit_data  <= data_nxt;
      err_length <= err_nxt;
    end
  end

`ifdef NOC_FLIT_PACKETIZER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) flit_parity <= 1'b0;
    else     flit_parity <= ^data_nxt;
  end
`else
  assign flit_parity = 1'b0;
`endif

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Randomized bench for noc_flit_packetizer against a packet-level model.
// Model: FIFO of expected flits built from requests and accepted words.
module tb_noc_flit_packetizer;

  localparam int DW = 32;
  localparam logic [5:0] MAXP = 6'd8;
  localparam longint TB_X = 0;
  localparam longint TB_Y = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_dest_x;
  logic [3:0]    req_dest_y;
  logic [1:0]    req_type;
  logic [7:0]    req_tag;
  logic [5:0]    req_length;
  logic          pay_valid;
  logic          pay_ready;
  logic [DW-1:0] pay_data;
  logic          flit_valid;
  logic          flit_ready;
  logic          flit_head;
  logic          flit_tail;
  logic [DW-1:0] flit_data;
  logic          flit_parity;
  logic          err_length;

  always #5 clk = ~clk;

  noc_flit_packetizer #(
    .X(0), .Y(0), .DATA_WIDTH(DW), .MAX_PAYLOAD(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest_x(req_dest_x), .req_dest_y(req_dest_y),
    .req_type(req_type), .req_tag(req_tag),
    .req_length(req_length),
    .pay_valid(pay_valid), .pay_ready(pay_ready),
    .pay_data(pay_data),
    .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_head(flit_head), .flit_tail(flit_tail),
    .flit_data(flit_data), .flit_parity(flit_parity),
    .err_length(err_length)
  );

  typedef struct {
    logic          head;
    logic          tail;
    logic [DW-1:0] data;
  } flit_t;

  typedef struct {
    logic [3:0] dx;
    logic [3:0] dy;
    logic [1:0] ty;
    logic [7:0] tag;
    logic [5:0] len;
  } req_t;

  int checks = 0;
  int failures = 0;
  flit_t q[$];
  req_t req_src[$];
  logic [DW-1:0] pay_src[$];
  bit m_body;
  int m_rem;
  bit m_err;
  int n_acc, n_err, req_fires, pay_fires;
  int req_pct = 100, pay_pct = 100, fr_pct = 100;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] head_word(req_t r, logic [5:0] len);
    longint w;
    w = longint'(r.dx) + 16 * longint'(r.dy) + 256 * TB_X
      + 4096 * TB_Y + 65536 * longint'(r.ty)
      + 262144 * longint'(r.tag) + 67108864 * longint'(len);
    return DW'(w);
  endfunction

  function automatic logic par(logic [DW-1:0] d);
`ifdef NOC_FLIT_PACKETIZER_PARITY_EN
    return ^d;
`else
    return 1'b0 & d[0];
`endif
  endfunction

  task automatic drive();
    req_valid = (req_src.size() != 0) &&
                ($urandom_range(99) < req_pct);
    if (req_src.size() != 0) begin
      req_dest_x = req_src[0].dx;
      req_dest_y = req_src[0].dy;
      req_type   = req_src[0].ty;
      req_tag    = req_src[0].tag;
      req_length = req_src[0].len;
    end
    pay_valid = (pay_src.size() != 0) &&
                ($urandom_range(99) < pay_pct);
    pay_data  = (pay_src.size() != 0) ? pay_src[0] : '0;
    flit_ready = ($urandom_range(99) < fr_pct);
  endtask

  task automatic step();
    bit of, rr, pr, rf, pf;
    logic [5:0] len;
    flit_t f;
    @(negedge clk);
    of = (q.size() == 0) || flit_ready;
    rr = !rst && !m_body && of;
    pr = !rst && m_body && of;
    check("req_ready", 64'(req_ready), 64'(rr));
    check("pay_ready", 64'(pay_ready), 64'(pr));
    check("err_length", 64'(err_length), 64'(m_err));
    check("flit_valid", 64'(flit_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("flit_head", 64'(flit_head), 64'(q[0].head));
      check("flit_tail", 64'(flit_tail), 64'(q[0].tail));
      check("flit_data", 64'(flit_data), 64'(q[0].data));
      check("flit_parity", 64'(flit_parity), 64'(par(q[0].data)));
    end
    if (err_length) n_err++;
    rf = req_valid && rr;
    pf = pay_valid && pr;
    if (rst) begin
      q.delete();
      m_body = 0;
      m_rem = 0;
      m_err = 0;
    end else begin
      if (q.size() != 0 && flit_ready) begin
        void'(q.pop_front());
        n_acc++;
      end
      m_err = 0;
      if (rf) begin
        len = (req_length > MAXP) ? MAXP : req_length;
        m_err = (req_length > MAXP);
        f.head = 1'b1;
        f.tail = (len == 6'd0);
        f.data = head_word(req_src[0], len);
        q.push_back(f);
        if (len != 6'd0) begin
          m_body = 1;
          m_rem = int'(len);
        end
        void'(req_src.pop_front());
        req_fires++;
      end
      if (pf) begin
        m_rem--;
        f.head = 1'b0;
        f.tail = (m_rem == 0);
        f.data = pay_data;
        q.push_back(f);
        if (m_rem == 0) m_body = 0;
        void'(pay_src.pop_front());
        pay_fires++;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_src.size() != 0 || m_body || q.size() != 0) && n < 20000) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(n < 20000), 64'(1));
  endtask

  task automatic add_req(int dx, int dy, int ty, int tag, int len);
    req_t r;
    r.dx = 4'(dx);
    r.dy = 4'(dy);
    r.ty = 2'(ty);
    r.tag = 8'(tag);
    r.len = 6'(len);
    req_src.push_back(r);
  endtask

  initial begin
    int a0, e0, p0, r0, len;
    rst = 1'b1;
    add_req(2, 1, 1, 8'h5A, 0);
    drive();
    @(posedge clk);
    #1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("head_only_data", 64'(flit_data), 64'(32'h01690012));
    check("head_only_ht", 64'({flit_head, flit_tail}), 64'(2'b11));
`ifdef NOC_FLIT_PACKETIZER_PARITY_EN
    check("head_only_par", 64'(flit_parity), 64'(1));
`endif
    drain();

    p0 = pay_fires;
    a0 = n_acc;
    add_req(3, 3, 2, 8'h11, 3);
    pay_src.push_back(32'hA);
    pay_src.push_back(32'hB);
    pay_src.push_back(32'hC);
    drive();
    repeat (4) step();
    check("len3_consec", 64'(pay_fires - p0), 64'(3));
    drain();
    check("len3_flits", 64'(n_acc - a0), 64'(4));

    add_req(1, 4, 0, 8'h22, 4);
    for (int i = 0; i < 4; i++) pay_src.push_back(32'h100 + 32'(i));
    drive();
    repeat (3) step();
    fr_pct = 0;
    drive();
    p0 = pay_fires;
    repeat (5) step();
    check("stall_no_pay", 64'(pay_fires - p0), 64'(0));
    fr_pct = 100;
    drive();
    drain();

    r0 = req_fires;
    p0 = pay_fires;
    add_req(5, 6, 3, 8'h33, 1);
    add_req(7, 8, 1, 8'h44, 1);
    pay_src.push_back(32'hDEAD0001);
    pay_src.push_back(32'hDEAD0002);
    drive();
    repeat (4) step();
    check("b2b_req", 64'(req_fires - r0), 64'(2));
    check("b2b_pay", 64'(pay_fires - p0), 64'(2));
    drain();

    e0 = n_err;
    p0 = pay_fires;
    add_req(9, 9, 0, 8'h55, 12);
    for (int i = 0; i < 12; i++) pay_src.push_back(32'h200 + 32'(i));
    drive();
    step();
    check("over_len_field", 64'(flit_data[31:26]), 64'(8));
    check("over_err", 64'(err_length), 64'(1));
    drain();
    check("over_err_once", 64'(n_err - e0), 64'(1));
    check("over_body", 64'(pay_fires - p0), 64'(8));
    pay_src.delete();
    drive();

    req_pct = 70;
    pay_pct = 70;
    fr_pct = 70;
    for (int k = 0; k < 200; k++) begin
      len = int'($urandom_range(0, 12));
      add_req(int'($urandom_range(15)), int'($urandom_range(15)),
              int'($urandom_range(3)), int'($urandom_range(255)), len);
      for (int i = 0; i < ((len > 8) ? 8 : len); i++)
        pay_src.push_back($urandom);
      if (k == 100) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      repeat ($urandom_range(0, 6)) step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_flit_packetizer.md
# noc_flit_packetizer

Network-interface transmitter for the local port of a mesh router. Takes one packet request (destination, type, tag, payload length) from a local endpoint, then a stream of payload words, and emits a head flit followed by payload flits on a valid/ready flit channel. It sits between an endpoint and the router's local input. Head/tail marking and output buffering are handled here, so the router sees well-formed packets only.

## Interface
Parameters:
- X, 0, source X coordinate, inserted into every head flit (0..15)
- Y, 0, source Y coordinate (0..15)
- DATA_WIDTH, 32, flit/payload data width (≥ 32)
- MAX_PAYLOAD, 8, maximum payload words per packet (1..63)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when both high
- req_dest_x  in  4  destination X
- req_dest_y  in  4  destination Y
- req_type  in  2  packet type, opaque
- req_tag  in  8  transaction tag, opaque
- req_length  in  6  payload words; 0 = head-only packet
- pay_valid  in  1  payload word valid
- pay_ready  out  1  payload word accepted when both high
- pay_data  in  DATA_WIDTH  payload word
- flit_valid  out  1  flit valid
- flit_ready  in  1  router accepts flit
- flit_head  out  1  head flit marker
- flit_tail  out  1  last flit of packet
- flit_data  out  DATA_WIDTH  flit payload
- flit_parity  out  1  even parity of flit_data (see Configuration)
- err_length  out  1  one-cycle pulse: req_length > MAX_PAYLOAD

## Operation
- One output register (flit_valid/head/tail/data/parity); out_free = !flit_valid || flit_ready.
- Head flit layout: [3:0] dest_x, [7:4] dest_y, [11:8] X, [15:12] Y, [17:16] type, [25:18] tag, [31:26] effective length, upper bits 0.
- FSM states IDLE, BODY; 6-bit counter `remaining`.
- IDLE: req_ready = out_free. On request handshake: load head flit, flit_head=1. Length 0 → flit_tail=1, stay IDLE. Else remaining=length, flit_tail=0, go BODY.
- Length > MAX_PAYLOAD: clamped to MAX_PAYLOAD (also in head field); err_length pulses the cycle after handshake.
- BODY: req_ready=0; pay_ready = out_free. On payload handshake: load flit_data=pay_data, flit_head=0, remaining−1; when remaining==1, flit_tail=1 and go IDLE.
- Output register cleared to flit_valid=0 when out_free and nothing loaded.
- Payload words arriving in IDLE are not accepted (pay_ready=0).

## Timing
- Reset: state IDLE, remaining 0, flit_valid/head/tail/parity 0, flit_data 0, err_length 0; req_ready and pay_ready forced 0 while rst=1.
- Reset mid-packet abandons the packet; no tail emitted.
- Latency: flit valid one cycle after the accepting handshake.
- Throughput: one flit per cycle; head of the next packet may follow a tail in the next cycle (no bubble).
- flit_valid && !flit_ready: all flit outputs held stable, req_ready/pay_ready low.
- Simultaneous flit accept and new load in the same cycle: register reloaded, flit_valid stays 1.

## Configuration
- NOC_FLIT_PACKETIZER_PARITY_EN defined: flit_parity = ^flit_data, registered with the flit.
- Undefined: flit_parity tied 0, no parity logic.

## Structure
- noc_config_pkg gains: head-flit field offsets/widths, packet type enum, and a head-flit pack function shared with the future receiver.
- No sub-module; FSM, counter and output register live in one module.

## Test plan
- Reset: rst=1 for 3 cycles with req_valid=1 → req_ready=0, flit_valid=0; after release req_ready=1.
- Head-only: X=Y=0, dest (2,1), type 1, tag 0x5A, length 0 → single flit head=1 tail=1 data 0x01690012; with parity macro flit_parity=1.
- Length 3, payload 0xA,0xB,0xC, flit_ready=1 → 4 flits on consecutive cycles; tail only on 0xC; head length field 3.
- Backpressure: flit_ready=0 for 5 cycles mid-body → flit_data stable, pay_ready=0, all words delivered in order afterwards.
- Back-to-back: two length-1 requests, req_valid held → head,body,head,body on 4 consecutive cycles.
- Overlength: req_length 12 with MAX_PAYLOAD=8 → err_length pulses once, head length field 8, exactly 8 body flits, tail on the 8th.
